prog_load_arbiter: RTL and testbench
====================================

Name: prog_load_arbiter

Overview:
- Owns the single memory port and shares it between a host program loader and the CPU instruction-fetch address (pcout).
- Sequences boot in this order:
  - hold the CPU in reset;
  - accept program words over a valid/ready handshake;
  - write them to consecutive addresses from 0;
  - wait a fixed settle time;
  - release the CPU and hand the memory address to the PC.
- Replaces ad-hoc testbench muxing of the memory address, data and write-enable lines.

Parameters:
- AW, 16, address width.
- DW, 16, data/instruction width.
- MEM_WORDS, 256, number of loadable words; the last legal address is MEM_WORDS-1.
- HOLD_CYCLES, 4, cycles the CPU stays in reset after the last write (minimum 1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ld_start  input  1  one-cycle pulse that begins a (re)load.
- ld_valid  input  1  loader word valid.
- ld_data  input  DW  loader word.
- ld_last  input  1  qualifies the final word of the program; sampled with ld_valid.
- ld_ready  output  1  arbiter can accept a word this cycle.
- cpu_addr  input  AW  CPU fetch address (PC).
- cpu_reset  output  1  reset to the CPU datapath.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  memory write enable (1 = write).
- words_loaded  output  AW  count of words accepted in the current/last load.
- busy  output  1  high in LOAD or HOLD.
- err_ovf  output  1  sticky: the loader exceeded MEM_WORDS without ld_last.

Behaviour:
- Reset values (synchronous reset):
  - state=IDLE, cpu_reset=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - words_loaded=0, busy=0, err_ovf=0;
  - write pointer ptr=0, hold counter=0.
- Reset effects: memory contents are not touched. A reset mid-LOAD abandons the load; the CPU stays in reset until the next completed load.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - cpu_reset=1, mem_we=0, mem_addr driven registered 0.
  - ld_start -> LOAD next cycle, with ptr=0, words_loaded=0, err_ovf=0.
- LOAD:
  - ld_ready=1 (combinational from state).
  - A beat occurs when ld_valid & ld_ready. The write is registered: the cycle after the beat, mem_we=1, mem_addr=ptr, mem_wdata=ld_data. Then ptr and words_loaded increment by 1.
  - mem_we is 0 in any cycle not following a beat.
  - Back-to-back beats give one write per cycle with no bubbles.
  - A beat with ld_last=1 -> HOLD. The final write still appears in the first HOLD cycle.
  - A beat at ptr=MEM_WORDS-1 with ld_last=0: the word is written, err_ovf is set, and the state goes to HOLD (treated as implicit last).
  - ptr never exceeds MEM_WORDS-1, so writes never wrap.
  - ld_start while in LOAD is ignored.
  - ld_valid without ld_ready (IDLE/HOLD/RUN) is ignored and has no side effects.
- HOLD:
  - ld_ready=0, cpu_reset=1.
  - The counter counts HOLD_CYCLES cycles, then -> RUN. The first cycle may carry the trailing write.
  - ld_start is ignored.
- RUN:
  - cpu_reset=0 starting the first RUN cycle, mem_we=0.
  - mem_addr=cpu_addr combinationally, so fetch has zero added latency. mem_wdata holds its last value.
  - ld_start in RUN: the next cycle cpu_reset=1 and the state is LOAD with ptr=0 (reload).
- busy=1 exactly in LOAD and HOLD.
- words_loaded holds its final value through HOLD and RUN until the next ld_start.
- Widths: ptr and words_loaded are AW bits; MEM_WORDS ≤ 2^AW.

Test Plan:
- Basic load, 20 words:
  - Stimulus: reset 3 cycles, ld_start, then 20 back-to-back beats 0xB010, 0xEA00, ..., 0x0FFF, with ld_last on word 20.
  - Required: mem_we high 20 consecutive cycles, each one cycle after its beat, at addr 0..19 with matching data; words_loaded=20; cpu_reset falls exactly 4 cycles after the last write cycle; mem_addr then tracks cpu_addr (drive 0x0005 -> mem_addr=0x0005 the same cycle).
- Gapped valid:
  - Stimulus: 3 words with ld_valid low 2 cycles between each.
  - Required: writes at addr 0,1,2 only in the cycles after beats; mem_we=0 during gaps; err_ovf=0.
- Overflow, MEM_WORDS=256:
  - Stimulus: 257 beats with no ld_last.
  - Required: 256 writes at addr 0..255; err_ovf=1; ld_ready=0 after beat 256; beat 257 ignored; addr never wraps to 0; RUN entered after HOLD.
- Reload from RUN:
  - Stimulus: in RUN, pulse ld_start, then load 2 words.
  - Required: cpu_reset=1 the next cycle; writes at addr 0 and 1; words_loaded=2; err_ovf cleared.
- Reset mid-LOAD:
  - Stimulus: assert reset after 5 beats.
  - Required: the next cycle state=IDLE, mem_we=0, words_loaded=0, cpu_reset=1; stray ld_valid in IDLE produces no write.
- Ignored start:
  - Stimulus: ld_start pulsed during LOAD and during HOLD.
  - Required: ptr, words_loaded and the hold count are unaffected.

Source files
------------

// File: rtl/prog_load_arbiter.sv
// Boot-time arbiter for the single memory port: streams loader words into memory from address 0,
// holds the CPU in reset for a settle period, then gives the address bus to the CPU PC.
module prog_load_arbiter #(
    parameter int unsigned AW          = 16,
    parameter int unsigned DW          = 16,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_reset,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [AW-1:0] words_loaded,
    output logic          busy,
    output logic          err_ovf
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] PtrLast  = AW'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StRun
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] words_q, words_d;
    logic          err_q, err_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        err_d   = err_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            StIdle, StRun: begin
                if (ld_start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                hold_d = '0;
                if (ld_valid) begin
                    // Write is registered: it appears on the port the cycle after the beat.
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = ld_data;
                    words_d = words_q + 1'b1;
                    if (ptr_q == PtrLast) begin
                        // Memory full: pointer stays put and the word is treated as the last.
                        state_d = StHold;
                        if (!ld_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        if (ld_last) begin
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ld_ready     = (state_q == StLoad);
    assign busy         = (state_q == StLoad) || (state_q == StHold);
    assign cpu_reset    = (state_q != StRun);
    // PC drives the address directly in RUN so fetches see no extra latency.
    assign mem_addr     = (state_q == StRun) ? cpu_addr : addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_we       = we_q;
    assign words_loaded = words_q;
    assign err_ovf      = err_q;

endmodule

// File: tb/tb_prog_load_arbiter.sv
// Directed bench for prog_load_arbiter: basic, gapped, overflow, reload, reset and ignored-start
// scenarios, each step checked with an immediate assertion against hand-derived values.
module tb_prog_load_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [15:0] cpu_addr;
    logic        cpu_reset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] words_loaded;
    logic        busy;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;

    prog_load_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .cpu_addr    (cpu_addr),
        .cpu_reset   (cpu_reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .words_loaded(words_loaded),
        .busy        (busy),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] basic_word(input int i);
        if (i == 0) return 16'hB010;
        if (i == 1) return 16'hEA00;
        if (i == 19) return 16'h0FFF;
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    initial begin
        reset    = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        cpu_addr = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_ovf), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // Basic load, 20 back-to-back words
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("basic_ready", 32'(ld_ready), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_we_pre", 32'(mem_we), 32'd0);
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1;
            ld_data  = basic_word(i);
            ld_last  = (i == 19);
            tick();
            chk("basic_we", 32'(mem_we), 32'd1);
            chk("basic_addr", 32'(mem_addr), 32'(i));
            chk("basic_data", 32'(mem_wdata), 32'(basic_word(i)));
            chk("basic_words", 32'(words_loaded), 32'(i + 1));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("basic_hold_ready", 32'(ld_ready), 32'd0);
        chk("basic_hold_cpu", 32'(cpu_reset), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("basic_hold_cpu_k", 32'(cpu_reset), 32'd1);
            chk("basic_hold_we", 32'(mem_we), 32'd0);
            chk("basic_hold_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("basic_run_cpu", 32'(cpu_reset), 32'd0);
        chk("basic_run_busy", 32'(busy), 32'd0);
        chk("basic_run_words", 32'(words_loaded), 32'd20);
        cpu_addr = 16'h0005;
        #1;
        chk("basic_pc_5", 32'(mem_addr), 32'h0005);
        cpu_addr = 16'h1234;
        #1;
        chk("basic_pc_1234", 32'(mem_addr), 32'h1234);
        chk("basic_run_we", 32'(mem_we), 32'd0);
        chk("basic_run_wdata", 32'(mem_wdata), 32'h0FFF);

        // Reload from RUN with gapped valid; ld_start in LOAD and HOLD must be ignored
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("gap_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("gap_words0", 32'(words_loaded), 32'd0);
        chk("gap_ready", 32'(ld_ready), 32'd1);
        for (int j = 0; j < 3; j++) begin
            ld_valid = 1'b1;
            ld_data  = 16'hA000 + 16'(j);
            ld_last  = (j == 2);
            ld_start = (j == 1);
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            ld_start = 1'b0;
            chk("gap_we", 32'(mem_we), 32'd1);
            chk("gap_addr", 32'(mem_addr), 32'(j));
            chk("gap_data", 32'(mem_wdata), 32'(16'hA000 + 16'(j)));
            if (j < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk("gap_idle_we", 32'(mem_we), 32'd0);
                    chk("gap_idle_words", 32'(words_loaded), 32'(j + 1));
                end
            end
        end
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("hold_start_busy", 32'(busy), 32'd1);
        chk("hold_start_words", 32'(words_loaded), 32'd3);
        tick();
        chk("hold_start_cpu", 32'(cpu_reset), 32'd1);
        tick();
        chk("gap_run_cpu", 32'(cpu_reset), 32'd0);
        chk("gap_err", 32'(err_ovf), 32'd0);
        chk("gap_run_words", 32'(words_loaded), 32'd3);

        // Overflow: 257 beats without ld_last
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 257; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'(i) ^ 16'h5A5A;
            ld_last  = 1'b0;
            tick();
            if (i < 256) begin
                chk("ovf_we", 32'(mem_we), 32'd1);
                chk("ovf_addr", 32'(mem_addr), 32'(i));
                chk("ovf_data", 32'(mem_wdata), 32'(16'(i) ^ 16'h5A5A));
            end else begin
                chk("ovf_beat257_we", 32'(mem_we), 32'd0);
                chk("ovf_no_wrap", 32'(mem_addr), 32'd255);
            end
            if (i == 255) begin
                chk("ovf_err", 32'(err_ovf), 32'd1);
                chk("ovf_ready", 32'(ld_ready), 32'd0);
            end
        end
        ld_valid = 1'b0;
        chk("ovf_words", 32'(words_loaded), 32'd256);
        tick();
        tick();
        chk("ovf_hold_cpu", 32'(cpu_reset), 32'd1);
        tick();
        chk("ovf_run_cpu", 32'(cpu_reset), 32'd0);
        chk("ovf_run_err", 32'(err_ovf), 32'd1);

        // Reload of 2 words clears err_ovf
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rl_err", 32'(err_ovf), 32'd0);
        chk("rl_words0", 32'(words_loaded), 32'd0);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'hC0DE + 16'(i);
            ld_last  = (i == 1);
            tick();
            chk("rl_we", 32'(mem_we), 32'd1);
            chk("rl_addr", 32'(mem_addr), 32'(i));
            chk("rl_data", 32'(mem_wdata), 32'(16'hC0DE + 16'(i)));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("rl_words", 32'(words_loaded), 32'd2);
        repeat (4) tick();
        chk("rl_run_cpu", 32'(cpu_reset), 32'd0);

        // Reset mid-LOAD after 5 beats
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'h7700 + 16'(i);
            tick();
            chk("mid_addr", 32'(mem_addr), 32'(i));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_we", 32'(mem_we), 32'd0);
        chk("mid_words", 32'(words_loaded), 32'd0);
        chk("mid_cpu", 32'(cpu_reset), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(ld_ready), 32'd0);
        chk("mid_addr0", 32'(mem_addr), 32'd0);
        tick();
        chk("stray_we", 32'(mem_we), 32'd0);
        chk("stray_words", 32'(words_loaded), 32'd0);
        ld_valid = 1'b0;
        tick();
        chk("stray_we2", 32'(mem_we), 32'd0);
        chk("stray_cpu", 32'(cpu_reset), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
